// File: rtl/ntt_bank_mem.sv
// ntt_bank_mem: NL-bank coefficient memory with a lane-to-bank crossbar for the NTT datapath.
//   i_clk, i_rstn            clock, asynchronous active-low reset
//   i_ren                    read issue for all lanes (1-cycle latency, o_rvalid follows)
//   i_wen                    tags this issue for write-back WB_DLY cycles later
//   i_lane_idx / i_lane_addr per-lane bank index and in-bank address
//   i_wdata                  per-lane write-back data, sampled on the write cycle
//   o_rdata / o_rvalid       per-lane read data, held while o_rvalid is low
//   o_conflict               sticky flag: two lanes targeted one bank in one issue
//   o_conflict_cnt           saturating count of conflicting issues
//   i_clr_err                synchronous clear of o_conflict and o_conflict_cnt
module ntt_bank_mem #(
  parameter int unsigned DW     = 32,
  parameter int unsigned NL     = 4,
  parameter int unsigned AW     = 9,
  parameter int unsigned WB_DLY = 8,
  localparam int unsigned BW    = $clog2(NL)
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_ren,
  input  logic             i_wen,
  input  logic [NL*BW-1:0] i_lane_idx,
  input  logic [NL*AW-1:0] i_lane_addr,
  input  logic [NL*DW-1:0] i_wdata,
  output logic [NL*DW-1:0] o_rdata,
  output logic             o_rvalid,
  output logic             o_conflict,
  output logic [15:0]      o_conflict_cnt,
  input  logic             i_clr_err
);

  localparam int unsigned Depth = 1 << AW;

  logic w_issue;
  assign w_issue = i_ren | i_wen;

  // Issue-time routing: each bank takes the address of the lowest lane mapped to it.
  logic [NL-1:0] w_rhit;
  logic [AW-1:0] w_raddr [NL];
  logic          w_conf;

  always_comb begin
    for (int b = 0; b < NL; b++) begin
      w_rhit[b]  = 1'b0;
      w_raddr[b] = '0;
      for (int i = NL - 1; i >= 0; i--) begin
        if (i_lane_idx[i*BW +: BW] == BW'(b)) begin
          w_rhit[b]  = 1'b1;
          w_raddr[b] = i_lane_addr[i*AW +: AW];
        end
      end
    end
    // Lanes equal banks, so any duplicated index leaves at least one bank unmapped.
    w_conf = ~&w_rhit;
  end

  // Write-back delay line carries the issue-time mapping.
  logic [WB_DLY-1:0]            r_dly_wen;
  logic [WB_DLY-1:0][NL*BW-1:0] r_dly_idx;
  logic [WB_DLY-1:0][NL*AW-1:0] r_dly_addr;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_dly_wen  <= '0;
      r_dly_idx  <= '0;
      r_dly_addr <= '0;
    end else begin
      r_dly_wen[0]  <= i_wen;
      r_dly_idx[0]  <= i_lane_idx;
      r_dly_addr[0] <= i_lane_addr;
      for (int k = 1; k < WB_DLY; k++) begin
        r_dly_wen[k]  <= r_dly_wen[k-1];
        r_dly_idx[k]  <= r_dly_idx[k-1];
        r_dly_addr[k] <= r_dly_addr[k-1];
      end
    end
  end

  // Write routing from the delayed mapping; losing lanes of a conflict are dropped.
  logic [NL-1:0] w_whit;
  logic [AW-1:0] w_waddr [NL];
  logic [DW-1:0] w_wdat  [NL];

  always_comb begin
    for (int b = 0; b < NL; b++) begin
      w_whit[b]  = 1'b0;
      w_waddr[b] = '0;
      w_wdat[b]  = '0;
      for (int i = NL - 1; i >= 0; i--) begin
        if (r_dly_idx[WB_DLY-1][i*BW +: BW] == BW'(b)) begin
          w_whit[b]  = 1'b1;
          w_waddr[b] = r_dly_addr[WB_DLY-1][i*AW +: AW];
          w_wdat[b]  = i_wdata[i*DW +: DW];
        end
      end
    end
  end

  logic [DW-1:0] w_bank_rd [NL];

  for (genvar g = 0; g < NL; g++) begin : g_bank
    logic [DW-1:0] r_mem [Depth];
    logic [DW-1:0] r_rd;

    // Read-first: the read samples the array before this edge's write lands.
    always_ff @(posedge i_clk) begin
      if (r_dly_wen[WB_DLY-1] && w_whit[g]) begin
        r_mem[w_waddr[g]] <= w_wdat[g];
      end
      if (i_ren) begin
        r_rd <= r_mem[w_raddr[g]];
      end
    end

    assign w_bank_rd[g] = r_rd;
  end

  logic [NL*BW-1:0] r_sel;
  logic             r_has_data;
  logic             r_rvalid;
  logic             r_conflict;
  logic [15:0]      r_cnt;
  logic             w_conf_issue;

  assign w_conf_issue = w_issue & w_conf;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_sel      <= '0;
      r_has_data <= 1'b0;
      r_rvalid   <= 1'b0;
      r_conflict <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_rvalid <= i_ren;
      if (i_ren) begin
        r_sel      <= i_lane_idx;
        r_has_data <= 1'b1;
      end
      // Clear takes priority; a conflict in the same cycle is then counted afresh.
      if (i_clr_err) begin
        r_conflict <= w_conf_issue;
        r_cnt      <= 16'(w_conf_issue);
      end else if (w_conf_issue) begin
        r_conflict <= 1'b1;
        if (r_cnt != 16'hFFFF) begin
          r_cnt <= r_cnt + 16'd1;
        end
      end
    end
  end

  // Output lane i follows the bank index it presented at issue.
  always_comb begin
    for (int i = 0; i < NL; i++) begin
      o_rdata[i*DW +: DW] = r_has_data ? w_bank_rd[r_sel[i*BW +: BW]] : '0;
    end
  end

  assign o_rvalid       = r_rvalid;
  assign o_conflict     = r_conflict;
  assign o_conflict_cnt = r_cnt;

endmodule

// File: tb/tb_ntt_bank_mem.sv
// Testbench for ntt_bank_mem: scenario tasks against a queue-based reference model.
module tb_ntt_bank_mem;
  localparam int DW  = 32;
  localparam int NL  = 4;
  localparam int AW  = 9;
  localparam int BW  = 2;
  localparam int DLY = 8;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             ren = 1'b0;
  logic             wen = 1'b0;
  logic             clr_err = 1'b0;
  logic [NL*BW-1:0] lane_idx = '0;
  logic [NL*AW-1:0] lane_addr = '0;
  logic [NL*DW-1:0] wdata = '0;
  logic [NL*DW-1:0] rdata;
  logic             rvalid;
  logic             conflict;
  logic [15:0]      conflict_cnt;

  always #5 clk = ~clk;

  ntt_bank_mem #(.DW(DW), .NL(NL), .AW(AW), .WB_DLY(DLY)) dut (
    .i_clk          (clk),
    .i_rstn         (rstn),
    .i_ren          (ren),
    .i_wen          (wen),
    .i_lane_idx     (lane_idx),
    .i_lane_addr    (lane_addr),
    .i_wdata        (wdata),
    .o_rdata        (rdata),
    .o_rvalid       (rvalid),
    .o_conflict     (conflict),
    .o_conflict_cnt (conflict_cnt),
    .i_clr_err      (clr_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: bank arrays plus a queue of pending write-backs with due cycles.
  typedef struct {
    int               due;
    logic [NL*BW-1:0] idx;
    logic [NL*AW-1:0] addr;
  } wb_t;

  logic [DW-1:0]    m_mem [NL][1<<AW];
  wb_t              pend[$];
  logic [NL*DW-1:0] exp_rdata  = '0;
  logic             exp_rvalid = 1'b0;
  logic             exp_conf   = 1'b0;
  logic [15:0]      exp_cnt    = '0;

  function automatic int first_lane(input logic [NL*BW-1:0] idx, input int b);
    for (int i = 0; i < NL; i++) begin
      if (int'(idx[i*BW +: BW]) == b) return i;
    end
    return -1;
  endfunction

  // Advance model and DUT by one clock edge using the currently driven inputs.
  task automatic step();
    int  b;
    int  w;
    bit  dup;
    wb_t e;
    if (!rstn) begin
      pend.delete();
      exp_rdata  = '0;
      exp_rvalid = 1'b0;
      exp_conf   = 1'b0;
      exp_cnt    = '0;
    end else begin
      dup = 1'b0;
      for (int i = 0; i < NL; i++)
        for (int j = i + 1; j < NL; j++)
          if (lane_idx[i*BW +: BW] == lane_idx[j*BW +: BW]) dup = 1'b1;
      if (ren) begin
        for (int i = 0; i < NL; i++) begin
          b = int'(lane_idx[i*BW +: BW]);
          w = first_lane(lane_idx, b);
          exp_rdata[i*DW +: DW] = m_mem[b][lane_addr[w*AW +: AW]];
        end
      end
      exp_rvalid = ren;
      while (pend.size() > 0 && pend[0].due == cyc) begin
        e = pend.pop_front();
        for (int bb = 0; bb < NL; bb++) begin
          w = first_lane(e.idx, bb);
          if (w >= 0) m_mem[bb][e.addr[w*AW +: AW]] = wdata[w*DW +: DW];
        end
      end
      if (wen) pend.push_back('{due: cyc + DLY, idx: lane_idx, addr: lane_addr});
      if (clr_err) begin
        exp_conf = (ren | wen) && dup;
        exp_cnt  = exp_conf ? 16'd1 : 16'd0;
      end else if ((ren | wen) && dup) begin
        exp_conf = 1'b1;
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_idle();
    ren       = 1'b0;
    wen       = 1'b0;
    clr_err   = 1'b0;
    lane_idx  = 8'($urandom());
    lane_addr = 36'({$urandom(), $urandom()});
    wdata     = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic preload(input logic [NL*BW-1:0] idx, input logic [NL*AW-1:0] addr,
                         input logic [NL*DW-1:0] wd);
    set_idle();
    wen = 1'b1; lane_idx = idx; lane_addr = addr;
    step();
    repeat (DLY - 1) begin set_idle(); step(); end
    set_idle();
    wdata = wd;
    step();
  endtask

  task automatic test_reset();
    rstn = 1'b0; ren = 1'b1; wen = 1'b0;
    repeat (3) step();
    n_checks++;
    if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %0b want 0", rvalid); end
    n_checks++;
    if (rdata !== '0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", rdata); end
    n_checks++;
    if (conflict !== 1'b0) begin n_fail++; $display("FAIL reset_conflict got %0b want 0", conflict); end
    n_checks++;
    if (conflict_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %h want 0", conflict_cnt); end
    rstn = 1'b1;
    set_idle();
    step();
  endtask

  task automatic test_permuted_read();
    logic [NL*DW-1:0] wd;
    wd = {32'h0D0D_0000, 32'h0C0C_0000, 32'h0B0B_0000, 32'hA5A5_0003};
    // lane i -> bank 3-i at address 5+i
    preload(8'h1B, {9'd8, 9'd7, 9'd6, 9'd5}, wd);
    set_idle();
    ren = 1'b1; lane_idx = 8'h1B; lane_addr = {9'd8, 9'd7, 9'd6, 9'd5};
    step();
    n_checks++;
    if (rvalid !== 1'b1) begin n_fail++; $display("FAIL perm_rvalid got %0b want 1", rvalid); end
    n_checks++;
    if (rdata[DW-1:0] !== 32'hA5A5_0003) begin
      n_fail++; $display("FAIL perm_lane0 got %h want a5a50003", rdata[DW-1:0]);
    end
    n_checks++;
    if (rdata !== wd || rdata !== exp_rdata) begin
      n_fail++; $display("FAIL perm_all got %h want %h", rdata, wd);
    end
    set_idle();
    step();
    n_checks++;
    if (rvalid !== 1'b0) begin n_fail++; $display("FAIL perm_rvalid_pulse got %0b want 0", rvalid); end
    n_checks++;
    if (rdata !== wd) begin n_fail++; $display("FAIL perm_hold got %h want %h", rdata, wd); end
  endtask

  task automatic test_writeback();
    logic [NL*DW-1:0] old_d;
    logic [NL*DW-1:0] new_d;
    old_d = {32'hAA00_0003, 32'hAA00_0002, 32'hAA00_0001, 32'hAA00_0000};
    new_d = {4{32'h0000_0055}};
    set_idle(); wen = 1'b1; lane_idx = 8'hE4; lane_addr = {4{9'd12}}; step();
    set_idle(); wen = 1'b1; lane_idx = 8'hB1; lane_addr = {4{9'd12}}; step();
    repeat (DLY - 2) begin set_idle(); step(); end
    set_idle(); wdata = old_d; step();
    // Second write lands on the same edge as this read: read must see the first write.
    set_idle(); wdata = new_d; ren = 1'b1; lane_idx = 8'hE4; lane_addr = {4{9'd12}}; step();
    n_checks++;
    if (rdata !== old_d || rdata !== exp_rdata) begin
      n_fail++; $display("FAIL wb_read_first got %h want %h", rdata, old_d);
    end
    set_idle(); ren = 1'b1; lane_idx = 8'hE4; lane_addr = {4{9'd12}}; step();
    n_checks++;
    if (rdata !== new_d) begin n_fail++; $display("FAIL wb_new_data got %h want %h", rdata, new_d); end
    set_idle(); ren = 1'b1; lane_idx = 8'hE4; lane_addr = {4{9'd12}}; step();
    n_checks++;
    if (rdata !== new_d || rdata !== exp_rdata) begin
      n_fail++; $display("FAIL wb_single_cycle got %h want %h", rdata, new_d);
    end
  endtask

  task automatic test_conflict();
    set_idle();
    ren = 1'b1;
    lane_idx  = {2'd2, 2'd1, 2'd0, 2'd0};
    lane_addr = {9'd12, 9'd12, 9'd8, 9'd12};
    step();
    n_checks++;
    if (conflict !== 1'b1) begin n_fail++; $display("FAIL conf_flag got %0b want 1", conflict); end
    n_checks++;
    if (conflict_cnt !== 16'd1) begin n_fail++; $display("FAIL conf_cnt1 got %h want 1", conflict_cnt); end
    n_checks++;
    if (rdata[2*DW-1:DW] !== rdata[DW-1:0] || rdata[2*DW-1:DW] !== 32'h55) begin
      n_fail++; $display("FAIL conf_loser got %h want %h", rdata[2*DW-1:DW], 32'h55);
    end
    n_checks++;
    if (rdata !== exp_rdata) begin n_fail++; $display("FAIL conf_rdata got %h want %h", rdata, exp_rdata); end
    repeat (69999) step();
    n_checks++;
    if (conflict_cnt !== 16'hFFFF || exp_cnt !== 16'hFFFF) begin
      n_fail++; $display("FAIL conf_saturate got %h want ffff", conflict_cnt);
    end
    n_checks++;
    if (conflict !== 1'b1) begin n_fail++; $display("FAIL conf_sticky got %0b want 1", conflict); end
    set_idle(); clr_err = 1'b1; step();
    n_checks++;
    if (conflict !== 1'b0 || conflict_cnt !== 16'd0) begin
      n_fail++; $display("FAIL conf_clear got %0b/%h want 0/0", conflict, conflict_cnt);
    end
    set_idle(); step();
    set_idle(); clr_err = 1'b1; ren = 1'b1;
    lane_idx = {2'd2, 2'd1, 2'd0, 2'd0}; lane_addr = {4{9'd12}};
    step();
    n_checks++;
    if (conflict !== exp_conf || conflict_cnt !== exp_cnt || conflict_cnt !== 16'd1) begin
      n_fail++; $display("FAIL conf_clr_and_new got %0b/%h want 1/1", conflict, conflict_cnt);
    end
    set_idle(); clr_err = 1'b1; step();
  endtask

  task automatic test_reset_midflight();
    logic [NL*DW-1:0] old_d;
    old_d = {32'h3030_0003, 32'h3030_0002, 32'h3030_0001, 32'h3030_0000};
    preload(8'hE4, {4{9'd30}}, old_d);
    set_idle(); wen = 1'b1; lane_idx = 8'hE4; lane_addr = {4{9'd30}}; step();
    repeat (2) begin set_idle(); step(); end
    set_idle(); rstn = 1'b0; step();
    n_checks++;
    if (rdata !== '0 || rvalid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_outputs got %h/%0b want 0/0", rdata, rvalid);
    end
    rstn = 1'b1;
    repeat (4) begin set_idle(); step(); end
    set_idle(); wdata = {4{32'hDEAD_BEEF}}; step();
    set_idle(); ren = 1'b1; lane_idx = 8'hE4; lane_addr = {4{9'd30}}; step();
    n_checks++;
    if (rdata !== old_d || rdata !== exp_rdata) begin
      n_fail++; $display("FAIL midrst_no_write got %h want %h", rdata, old_d);
    end
  endtask

  task automatic test_streaming();
    int p[NL];
    int j;
    int t;
    set_idle(); clr_err = 1'b1; step();
    for (int a = 0; a < 16; a++) begin
      set_idle(); wen = 1'b1; lane_idx = 8'hE4; lane_addr = {4{9'(a)}}; step();
    end
    repeat (DLY + 1) begin set_idle(); step(); end
    for (int n = 0; n < 64; n++) begin
      set_idle();
      ren = 1'b1;
      wen = 1'($urandom_range(0, 1));
      for (int i = 0; i < NL; i++) p[i] = i;
      for (int i = NL - 1; i > 0; i--) begin
        j = int'($urandom_range(0, i));
        t = p[i]; p[i] = p[j]; p[j] = t;
      end
      for (int i = 0; i < NL; i++) begin
        lane_idx[i*BW +: BW]  = BW'(p[i]);
        lane_addr[i*AW +: AW] = 9'($urandom_range(0, 15));
      end
      step();
      n_checks++;
      if (rdata !== exp_rdata || rvalid !== 1'b1) begin
        n_fail++; $display("FAIL stream_%0d got %h/%0b want %h/1", n, rdata, rvalid, exp_rdata);
      end
    end
    repeat (DLY + 1) begin set_idle(); step(); end
    for (int a = 0; a < 16; a += 5) begin
      set_idle(); ren = 1'b1; lane_idx = 8'h1B; lane_addr = {4{9'(a)}}; step();
      n_checks++;
      if (rdata !== exp_rdata) begin
        n_fail++; $display("FAIL stream_final_%0d got %h want %h", a, rdata, exp_rdata);
      end
    end
    n_checks++;
    if (conflict !== 1'b0 || conflict_cnt !== 16'd0) begin
      n_fail++; $display("FAIL stream_no_conflict got %0b/%h want 0/0", conflict, conflict_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_permuted_read();
    test_writeback();
    test_conflict();
    test_reset_midflight();
    test_streaming();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
